// File: rtl/wbi_pkg.sv
// rtl/wbi_pkg.sv - shared types for the wishbone interconnect slave port
// Response field order here matches the packed FIFO word in wbi_slave_port.
package wbi_pkg;

  localparam int TID_W  = 4;
  localparam int RES_DW = 32;

  typedef enum logic [1:0] {
    RT_NONE,
    RT_LOCAL,
    RT_FWD
  } route_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [RES_DW-1:0] dat;
    logic              ack;
    logic              lack;
    logic              err;
    logic [TID_W-1:0]  tid;
  } res_t;

endpackage

// File: rtl/wbi_res_fifo.sv
// rtl/wbi_res_fifo.sv - synchronous valid/ready response FIFO
// A push while full is taken only when the head is popped in the same cycle.
module wbi_res_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid_i,
  input  logic [W-1:0] wr_data_i,
  output logic         full_o,
  output logic         rd_valid_o,
  input  logic         rd_ready_i,
  output logic [W-1:0] rd_data_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          push, pop;

  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rptr_q];
  assign pop        = rd_valid_o & rd_ready_i;
  assign push       = wr_valid_i & (~full_o | pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/wbi_slave_port.sv
// rtl/wbi_slave_port.sv - daisy-chain slave node: decode, local wishbone FSM, response merge
// Hits run on the local bus; misses pass straight through to the downstream node.
module wbi_slave_port
  import wbi_pkg::*;
#(
  parameter int          AW   = 32,
  parameter int          DW   = 32,
  parameter int          BW   = 4,
  parameter int          BL   = 10,
  parameter logic [AW-1:0] BASE = 32'h0000_0000,
  parameter logic [AW-1:0] MASK = 32'hF000_0000,
  parameter int          RDP  = 2
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          wbp_cmd_wval_i,
  output logic          wbp_cmd_wrdy_o,
  input  logic [AW-1:0] wbp_cmd_adr_i,
  input  logic          wbp_cmd_we_i,
  input  logic [DW-1:0] wbp_cmd_dat_i,
  input  logic [BW-1:0] wbp_cmd_sel_i,
  input  logic [3:0]    wbp_cmd_tid_i,
  input  logic [BL-1:0] wbp_cmd_bl_i,
  output logic          wbp_res_rval_o,
  input  logic          wbp_res_rrdy_i,
  output logic [DW-1:0] wbp_res_dat_o,
  output logic          wbp_res_ack_o,
  output logic          wbp_res_lack_o,
  output logic          wbp_res_err_o,
  output logic [3:0]    wbp_res_tid_o,
  output logic          wbd_cmd_wval_o,
  input  logic          wbd_cmd_wrdy_i,
  output logic [AW-1:0] wbd_cmd_adr_o,
  output logic          wbd_cmd_we_o,
  output logic [DW-1:0] wbd_cmd_dat_o,
  output logic [BW-1:0] wbd_cmd_sel_o,
  output logic [3:0]    wbd_cmd_tid_o,
  output logic [BL-1:0] wbd_cmd_bl_o,
  input  logic          wbd_res_rval_i,
  output logic          wbd_res_rrdy_o,
  input  logic [DW-1:0] wbd_res_dat_i,
  input  logic          wbd_res_ack_i,
  input  logic          wbd_res_lack_i,
  input  logic          wbd_res_err_i,
  input  logic [3:0]    wbd_res_tid_i,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic          wbs_we_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [BW-1:0] wbs_sel_o,
  output logic [BL-1:0] wbs_bl_o,
  output logic          wbs_bry_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_lack_i,
  input  logic          wbs_err_i
);

  localparam int RW = DW + 3 + TID_W;

  route_e        route_q, route_cur;
  state_e        state_q;
  logic          cyc_q, stb_q, we_q, err_q, grant_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [BW-1:0] sel_q;
  logic [BL-1:0] bl_q, beat_cnt_q, fwd_cnt_q, eff_bl;
  logic [3:0]    tid_q;

  logic          hit, fwd, local_rdy, cmd_fire, loc_fire, fwd_fire;
  logic          last_beat, ack_v, rd_lack;
  logic          fifo_wr_valid, fifo_full, fifo_rd_valid, fifo_rd_ready;
  logic [RW-1:0] fifo_wr_data, fifo_rd_data;
  logic          sel_d;

  assign hit       = ((wbp_cmd_adr_i & MASK) == BASE);
  assign eff_bl    = (wbp_cmd_bl_i == '0) ? BL'(1) : wbp_cmd_bl_i;
  assign route_cur = (route_q == RT_NONE) ? (hit ? RT_LOCAL : RT_FWD) : route_q;
  assign fwd       = (route_cur == RT_FWD);

  assign wbd_cmd_wval_o = wbp_cmd_wval_i & fwd;
  assign wbd_cmd_adr_o  = wbp_cmd_adr_i;
  assign wbd_cmd_we_o   = wbp_cmd_we_i;
  assign wbd_cmd_dat_o  = wbp_cmd_dat_i;
  assign wbd_cmd_sel_o  = wbp_cmd_sel_i;
  assign wbd_cmd_tid_o  = wbp_cmd_tid_i;
  assign wbd_cmd_bl_o   = wbp_cmd_bl_i;

  assign last_beat = (beat_cnt_q == BL'(1));
  assign rd_lack   = last_beat | wbs_lack_i | wbs_err_i;

  always_comb begin
    wbs_bry_o = 1'b0;
    local_rdy = 1'b0;
    case (state_q)
      ST_IDLE: local_rdy = 1'b1;
      ST_RD:   wbs_bry_o = ~fifo_full;
      ST_WR:   wbs_bry_o = stb_q & (last_beat ? ~fifo_full : 1'b1);
      default: ;
    endcase
    ack_v = wbs_ack_i & wbs_bry_o & stb_q;
    // A mid-burst write ack frees the data register, so the next beat loads without a bubble.
    if (state_q == ST_WR) local_rdy = ~stb_q | (ack_v & ~last_beat);
  end

  assign wbp_cmd_wrdy_o = wbp_cmd_wval_i & (fwd ? wbd_cmd_wrdy_i : local_rdy);
  assign cmd_fire       = wbp_cmd_wval_i & wbp_cmd_wrdy_o;
  assign loc_fire       = cmd_fire & ~fwd;
  assign fwd_fire       = cmd_fire & fwd;

  assign fifo_wr_valid = ack_v & ((state_q == ST_RD) | last_beat);
  assign fifo_wr_data  = (state_q == ST_RD)
                       ? {wbs_dat_i, 1'b1, rd_lack, wbs_err_i, tid_q}
                       : {{DW{1'b0}}, 1'b1, 1'b1, err_q | wbs_err_i, tid_q};

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      route_q    <= RT_NONE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      bl_q       <= '0;
      tid_q      <= '0;
      beat_cnt_q <= '0;
      fwd_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (loc_fire) begin
          adr_q      <= wbp_cmd_adr_i;
          dat_q      <= wbp_cmd_dat_i;
          sel_q      <= wbp_cmd_sel_i;
          tid_q      <= wbp_cmd_tid_i;
          bl_q       <= wbp_cmd_bl_i;
          we_q       <= wbp_cmd_we_i;
          beat_cnt_q <= eff_bl;
          err_q      <= 1'b0;
          cyc_q      <= 1'b1;
          stb_q      <= 1'b1;
          route_q    <= RT_LOCAL;
          state_q    <= wbp_cmd_we_i ? ST_WR : ST_RD;
        end
        ST_RD: if (ack_v) begin
          beat_cnt_q <= beat_cnt_q - 1'b1;
          if (rd_lack) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_WR: begin
          if (ack_v) begin
            beat_cnt_q <= beat_cnt_q - 1'b1;
            err_q      <= err_q | wbs_err_i;
            if (last_beat) begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              state_q <= ST_DONE;
            end else if (!loc_fire) begin
              stb_q <= 1'b0;
            end
          end
          if (loc_fire) begin
            adr_q <= wbp_cmd_adr_i;
            dat_q <= wbp_cmd_dat_i;
            sel_q <= wbp_cmd_sel_i;
            stb_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          route_q <= RT_NONE;
        end
      endcase
      // Forwarded write bursts hold the route until every beat has gone downstream.
      if (fwd_fire) begin
        if (route_q == RT_NONE) begin
          if (wbp_cmd_we_i && (eff_bl > BL'(1))) begin
            route_q   <= RT_FWD;
            fwd_cnt_q <= eff_bl - 1'b1;
          end
        end else begin
          fwd_cnt_q <= fwd_cnt_q - 1'b1;
          if (fwd_cnt_q == BL'(1)) route_q <= RT_NONE;
        end
      end
    end
  end

  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = stb_q;
  assign wbs_we_o  = we_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
  assign wbs_sel_o = sel_q;
  assign wbs_bl_o  = bl_q;

  wbi_res_fifo #(.W(RW), .DEPTH(RDP)) u_res_fifo (
    .clk        (mclk),
    .rst_n      (reset_n),
    .wr_valid_i (fifo_wr_valid),
    .wr_data_i  (fifo_wr_data),
    .full_o     (fifo_full),
    .rd_valid_o (fifo_rd_valid),
    .rd_ready_i (fifo_rd_ready),
    .rd_data_o  (fifo_rd_data)
  );

  // grant_q: 0 favours the local FIFO, 1 the downstream chain, when both are valid.
  assign sel_d          = wbd_res_rval_i & (~fifo_rd_valid | grant_q);
  assign wbp_res_rval_o = fifo_rd_valid | wbd_res_rval_i;
  assign fifo_rd_ready  = wbp_res_rrdy_i & fifo_rd_valid & ~sel_d;
  assign wbd_res_rrdy_o = wbp_res_rrdy_i & sel_d;

  always_comb begin
    {wbp_res_dat_o, wbp_res_ack_o, wbp_res_lack_o, wbp_res_err_o, wbp_res_tid_o} = '0;
    if (sel_d)
      {wbp_res_dat_o, wbp_res_ack_o, wbp_res_lack_o, wbp_res_err_o, wbp_res_tid_o} =
        {wbd_res_dat_i, wbd_res_ack_i, wbd_res_lack_i, wbd_res_err_i, wbd_res_tid_i};
    else if (fifo_rd_valid)
      {wbp_res_dat_o, wbp_res_ack_o, wbp_res_lack_o, wbp_res_err_o, wbp_res_tid_o} = fifo_rd_data;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)            grant_q <= 1'b0;
    else if (wbp_res_rval_o) grant_q <= wbp_res_rrdy_i ? ~sel_d : sel_d;
  end

endmodule

// File: tb/tb_wbi_slave_port.sv
// tb/tb_wbi_slave_port.sv - directed self-checking bench for wbi_slave_port
module tb_wbi_slave_port;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic        wbp_cmd_wval_i, wbp_cmd_wrdy_o, wbp_cmd_we_i;
  logic [31:0] wbp_cmd_adr_i, wbp_cmd_dat_i;
  logic [3:0]  wbp_cmd_sel_i, wbp_cmd_tid_i;
  logic [9:0]  wbp_cmd_bl_i;
  logic        wbp_res_rval_o, wbp_res_rrdy_i, wbp_res_ack_o, wbp_res_lack_o, wbp_res_err_o;
  logic [31:0] wbp_res_dat_o;
  logic [3:0]  wbp_res_tid_o;
  logic        wbd_cmd_wval_o, wbd_cmd_wrdy_i, wbd_cmd_we_o;
  logic [31:0] wbd_cmd_adr_o, wbd_cmd_dat_o;
  logic [3:0]  wbd_cmd_sel_o, wbd_cmd_tid_o;
  logic [9:0]  wbd_cmd_bl_o;
  logic        wbd_res_rval_i, wbd_res_rrdy_o, wbd_res_ack_i, wbd_res_lack_i, wbd_res_err_i;
  logic [31:0] wbd_res_dat_i;
  logic [3:0]  wbd_res_tid_i;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_bry_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbs_sel_o;
  logic [9:0]  wbs_bl_o;
  logic        wbs_ack_i, wbs_lack_i, wbs_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  wbi_slave_port #(
    .AW(32), .DW(32), .BW(4), .BL(10),
    .BASE(32'h3000_0000), .MASK(32'hF000_0000), .RDP(2)
  ) dut (
    .mclk(mclk), .reset_n(reset_n),
    .wbp_cmd_wval_i(wbp_cmd_wval_i), .wbp_cmd_wrdy_o(wbp_cmd_wrdy_o),
    .wbp_cmd_adr_i(wbp_cmd_adr_i), .wbp_cmd_we_i(wbp_cmd_we_i), .wbp_cmd_dat_i(wbp_cmd_dat_i),
    .wbp_cmd_sel_i(wbp_cmd_sel_i), .wbp_cmd_tid_i(wbp_cmd_tid_i), .wbp_cmd_bl_i(wbp_cmd_bl_i),
    .wbp_res_rval_o(wbp_res_rval_o), .wbp_res_rrdy_i(wbp_res_rrdy_i),
    .wbp_res_dat_o(wbp_res_dat_o), .wbp_res_ack_o(wbp_res_ack_o), .wbp_res_lack_o(wbp_res_lack_o),
    .wbp_res_err_o(wbp_res_err_o), .wbp_res_tid_o(wbp_res_tid_o),
    .wbd_cmd_wval_o(wbd_cmd_wval_o), .wbd_cmd_wrdy_i(wbd_cmd_wrdy_i),
    .wbd_cmd_adr_o(wbd_cmd_adr_o), .wbd_cmd_we_o(wbd_cmd_we_o), .wbd_cmd_dat_o(wbd_cmd_dat_o),
    .wbd_cmd_sel_o(wbd_cmd_sel_o), .wbd_cmd_tid_o(wbd_cmd_tid_o), .wbd_cmd_bl_o(wbd_cmd_bl_o),
    .wbd_res_rval_i(wbd_res_rval_i), .wbd_res_rrdy_o(wbd_res_rrdy_o),
    .wbd_res_dat_i(wbd_res_dat_i), .wbd_res_ack_i(wbd_res_ack_i), .wbd_res_lack_i(wbd_res_lack_i),
    .wbd_res_err_i(wbd_res_err_i), .wbd_res_tid_i(wbd_res_tid_i),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_bl_o(wbs_bl_o), .wbs_bry_o(wbs_bry_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_lack_i(wbs_lack_i), .wbs_err_i(wbs_err_i)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic cmd(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] tid, input logic [9:0] bl);
    wbp_cmd_wval_i = 1'b1;
    wbp_cmd_adr_i  = adr;
    wbp_cmd_we_i   = we;
    wbp_cmd_dat_i  = dat;
    wbp_cmd_sel_i  = 4'hF;
    wbp_cmd_tid_i  = tid;
    wbp_cmd_bl_i   = bl;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] dat, input logic lack,
                         input logic err, input logic [3:0] tid);
    chk({tag, "_rval"}, wbp_res_rval_o, 1'b1);
    chk({tag, "_dat"},  wbp_res_dat_o, dat);
    chk({tag, "_ack"},  wbp_res_ack_o, 1'b1);
    chk({tag, "_lack"}, wbp_res_lack_o, lack);
    chk({tag, "_err"},  wbp_res_err_o, err);
    chk({tag, "_tid"},  wbp_res_tid_o, tid);
  endtask

  initial begin
    reset_n = 1'b0;
    wbp_cmd_wval_i = 0; wbp_cmd_adr_i = 0; wbp_cmd_we_i = 0; wbp_cmd_dat_i = 0;
    wbp_cmd_sel_i = 0; wbp_cmd_tid_i = 0; wbp_cmd_bl_i = 0; wbp_res_rrdy_i = 0;
    wbd_cmd_wrdy_i = 0; wbd_res_rval_i = 0; wbd_res_dat_i = 0; wbd_res_ack_i = 0;
    wbd_res_lack_i = 0; wbd_res_err_i = 0; wbd_res_tid_i = 0;
    wbs_dat_i = 0; wbs_ack_i = 0; wbs_lack_i = 0; wbs_err_i = 0;
    #2;
    chk("rst_cyc", wbs_cyc_o, 1'b0);
    chk("rst_stb", wbs_stb_o, 1'b0);
    chk("rst_bry", wbs_bry_o, 1'b0);
    chk("rst_rval", wbp_res_rval_o, 1'b0);
    chk("rst_wrdy", wbp_cmd_wrdy_o, 1'b0);
    chk("rst_dwval", wbd_cmd_wval_o, 1'b0);
    step(); step();
    reset_n = 1'b1;

    // single read hit
    cmd(32'h3000_0010, 1'b0, 32'h0, 4'd2, 10'd1);
    #1;
    chk("rd_wrdy", wbp_cmd_wrdy_o, 1'b1);
    chk("rd_no_fwd", wbd_cmd_wval_o, 1'b0);
    step();
    wbp_cmd_wval_i = 1'b0;
    #1;
    chk("rd_cyc", wbs_cyc_o, 1'b1);
    chk("rd_stb", wbs_stb_o, 1'b1);
    chk("rd_we", wbs_we_o, 1'b0);
    chk("rd_adr", wbs_adr_o, 32'h3000_0010);
    chk("rd_bry", wbs_bry_o, 1'b1);
    chk("rd_no_fwd2", wbd_cmd_wval_o, 1'b0);
    wbs_ack_i = 1; wbs_lack_i = 1; wbs_dat_i = 32'hDEAD_BEEF;
    step();
    wbs_ack_i = 0; wbs_lack_i = 0; wbs_dat_i = 0;
    #1;
    chk_res("rd_res", 32'hDEAD_BEEF, 1'b1, 1'b0, 4'd2);
    chk("rd_done_cyc", wbs_cyc_o, 1'b0);
    wbp_res_rrdy_i = 1;
    step();
    wbp_res_rrdy_i = 0;
    #1;
    chk("rd_popped", wbp_res_rval_o, 1'b0);

    // miss forwarded combinationally
    cmd(32'h1000_0000, 1'b1, 32'h55, 4'd3, 10'd1);
    wbd_cmd_wrdy_i = 0;
    #1;
    chk("miss_wval", wbd_cmd_wval_o, 1'b1);
    chk("miss_adr", wbd_cmd_adr_o, 32'h1000_0000);
    chk("miss_dat", wbd_cmd_dat_o, 32'h55);
    chk("miss_tid", wbd_cmd_tid_o, 4'd3);
    chk("miss_wrdy0", wbp_cmd_wrdy_o, 1'b0);
    step();
    chk("miss_cyc", wbs_cyc_o, 1'b0);
    wbd_cmd_wrdy_i = 1;
    #1;
    chk("miss_wrdy1", wbp_cmd_wrdy_o, 1'b1);
    step();
    wbp_cmd_wval_i = 0; wbd_cmd_wrdy_i = 0;
    #1;
    chk("miss_cyc2", wbs_cyc_o, 1'b0);

    // write burst, 4 beats, slave acks back to back
    cmd(32'h3000_0100, 1'b1, 32'd1, 4'd5, 10'd4);
    #1;
    chk("wr_wrdy", wbp_cmd_wrdy_o, 1'b1);
    step();
    wbp_cmd_dat_i = 32'd2;
    wbs_ack_i = 1;
    #1;
    chk("wr_dat1", wbs_dat_o, 32'd1);
    chk("wr_we", wbs_we_o, 1'b1);
    chk("wr_wrdy_b1", wbp_cmd_wrdy_o, 1'b1);
    step();
    wbp_cmd_dat_i = 32'd3;
    #1;
    chk("wr_dat2", wbs_dat_o, 32'd2);
    chk("wr_stb2", wbs_stb_o, 1'b1);
    step();
    wbp_cmd_dat_i = 32'd4;
    #1;
    chk("wr_dat3", wbs_dat_o, 32'd3);
    chk("wr_stb3", wbs_stb_o, 1'b1);
    step();
    wbp_cmd_wval_i = 0;
    #1;
    chk("wr_dat4", wbs_dat_o, 32'd4);
    chk("wr_stb4", wbs_stb_o, 1'b1);
    chk("wr_bry4", wbs_bry_o, 1'b1);
    chk("wr_no_res", wbp_res_rval_o, 1'b0);
    step();
    wbs_ack_i = 0;
    #1;
    chk_res("wr_res", 32'h0, 1'b1, 1'b0, 4'd5);
    chk("wr_stb_off", wbs_stb_o, 1'b0);
    wbp_res_rrdy_i = 1;
    step();
    wbp_res_rrdy_i = 0;
    #1;
    chk("wr_one_res", wbp_res_rval_o, 1'b0);

    // read burst of 4 with an error on beat 2
    cmd(32'h3000_0200, 1'b0, 32'h0, 4'd7, 10'd4);
    step();
    wbp_cmd_wval_i = 0;
    wbs_ack_i = 1; wbs_dat_i = 32'hA1;
    step();
    wbs_dat_i = 32'hA2; wbs_err_i = 1;
    #1;
    chk("rde_bry", wbs_bry_o, 1'b1);
    step();
    wbs_ack_i = 0; wbs_err_i = 0;
    #1;
    chk("rde_cyc", wbs_cyc_o, 1'b0);
    chk_res("rde_r1", 32'hA1, 1'b0, 1'b0, 4'd7);
    wbp_res_rrdy_i = 1;
    step();
    #1;
    chk_res("rde_r2", 32'hA2, 1'b1, 1'b1, 4'd7);
    step();
    wbp_res_rrdy_i = 0;
    #1;
    chk("rde_two_only", wbp_res_rval_o, 1'b0);

    // fill the FIFO, then merge against downstream
    cmd(32'h3000_0300, 1'b0, 32'h0, 4'd1, 10'd4);
    #1;
    chk("idle_after_err", wbp_cmd_wrdy_o, 1'b1);
    step();
    wbp_cmd_wval_i = 0;
    wbs_ack_i = 1; wbs_dat_i = 32'h11;
    step();
    wbs_dat_i = 32'h12;
    step();
    wbs_ack_i = 0;
    #1;
    chk("full_bry", wbs_bry_o, 1'b0);
    step();
    chk("full_bry2", wbs_bry_o, 1'b0);
    chk("full_cyc", wbs_cyc_o, 1'b1);
    wbd_res_rval_i = 1; wbd_res_dat_i = 32'hD1; wbd_res_ack_i = 1;
    wbd_res_lack_i = 1; wbd_res_tid_i = 4'd9;
    wbp_res_rrdy_i = 1;
    #1;
    chk("mg_a_dat", wbp_res_dat_o, 32'h11);
    chk("mg_a_drdy", wbd_res_rrdy_o, 1'b0);
    step();
    wbp_res_rrdy_i = 0;
    #1;
    chk("mg_b_dat", wbp_res_dat_o, 32'hD1);
    chk("mg_b_tid", wbp_res_tid_o, 4'd9);
    chk("mg_b_drdy", wbd_res_rrdy_o, 1'b0);
    step();
    wbp_res_rrdy_i = 1;
    #1;
    chk("mg_c_dat", wbp_res_dat_o, 32'hD1);
    chk("mg_c_drdy", wbd_res_rrdy_o, 1'b1);
    step();
    wbd_res_dat_i = 32'hD2;
    #1;
    chk("mg_d_dat", wbp_res_dat_o, 32'h12);
    chk("mg_d_drdy", wbd_res_rrdy_o, 1'b0);
    chk("mg_d_bry", wbs_bry_o, 1'b1);
    step();
    wbd_res_rval_i = 0; wbp_res_rrdy_i = 0;
    wbs_ack_i = 1; wbs_dat_i = 32'h13;
    step();
    wbs_dat_i = 32'h14;
    step();
    wbs_ack_i = 0;
    #1;
    chk("mg_done_cyc", wbs_cyc_o, 1'b0);
    wbp_res_rrdy_i = 1;
    #1;
    chk_res("mg_r3", 32'h13, 1'b0, 1'b0, 4'd1);
    step();
    chk_res("mg_r4", 32'h14, 1'b1, 1'b0, 4'd1);
    step();
    wbp_res_rrdy_i = 0;

    // reset in the middle of a read burst
    cmd(32'h3000_0400, 1'b0, 32'h0, 4'd4, 10'd4);
    step();
    wbp_cmd_wval_i = 0;
    wbs_ack_i = 1; wbs_dat_i = 32'h21;
    step();
    #1;
    chk("pre_rst_cyc", wbs_cyc_o, 1'b1);
    chk("pre_rst_rval", wbp_res_rval_o, 1'b1);
    reset_n = 0;
    #1;
    chk("mid_rst_cyc", wbs_cyc_o, 1'b0);
    chk("mid_rst_stb", wbs_stb_o, 1'b0);
    chk("mid_rst_rval", wbp_res_rval_o, 1'b0);
    chk("mid_rst_bry", wbs_bry_o, 1'b0);
    wbs_ack_i = 0; wbs_dat_i = 0;
    step(); step();
    reset_n = 1;
    cmd(32'h3000_0020, 1'b0, 32'h0, 4'd6, 10'd1);
    #1;
    chk("post_rst_wrdy", wbp_cmd_wrdy_o, 1'b1);
    step();
    wbp_cmd_wval_i = 0;
    wbs_ack_i = 1; wbs_lack_i = 1; wbs_dat_i = 32'hCAFE_F00D;
    step();
    wbs_ack_i = 0; wbs_lack_i = 0;
    #1;
    chk_res("post_rst_res", 32'hCAFE_F00D, 1'b1, 1'b0, 4'd6);
    wbp_res_rrdy_i = 1;
    step();
    wbp_res_rrdy_i = 0;
    #1;
    chk("post_rst_empty", wbp_res_rval_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wbi_slave_port.md
Name: wbi_slave_port

Overview:
- Target-side node of the daisy-chained wishbone interconnect; the responder counterpart of the master port.
- Accepts tagged command beats from the upstream chain, address-decodes each transaction, and either executes it on a local wishbone slave bus or forwards it unchanged downstream.
- Merges local responses with downstream responses onto the upstream response channel, tagged by tid.

Parameters:
- AW, 32, address width
- DW, 32, data width
- BW, 4, byte-enable width (DW/8)
- BL, 10, burst-length width
- BASE, 32'h0000_0000, slave base address
- MASK, 32'hF000_0000, decode mask; hit = (adr & MASK) == BASE
- RDP, 2, local response FIFO depth (power of 2, >=2)

Ports:
- mclk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- wbp_cmd_wval_i / wbp_cmd_wrdy_o  in/out  1  upstream command valid/ready
- wbp_cmd_adr_i  in  AW; wbp_cmd_we_i  in  1; wbp_cmd_dat_i  in  DW; wbp_cmd_sel_i  in  BW; wbp_cmd_tid_i  in  4; wbp_cmd_bl_i  in  BL
- wbp_res_rval_o / wbp_res_rrdy_i  out/in  1  upstream response valid/ready
- wbp_res_dat_o  out  DW; wbp_res_ack_o, wbp_res_lack_o, wbp_res_err_o  out  1 each; wbp_res_tid_o  out  4
- wbd_cmd_*  out (wrdy in)  same widths as wbp_cmd_*, downstream command
- wbd_res_*  in (rrdy out)  same widths as wbp_res_*, downstream response
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1; wbs_adr_o  out  AW; wbs_dat_o  out  DW; wbs_sel_o  out  BW; wbs_bl_o  out  BL; wbs_bry_o  out  1
- wbs_dat_i  in  DW; wbs_ack_i, wbs_lack_i, wbs_err_i  in  1

Behaviour:
- Reset: every output 0; FSM=IDLE; route=NONE; FIFO empty; rr grant=local.
- Protocol: one command item = one beat. A transaction is 1 header beat (read), or bl beats (write; adr/tid/bl repeated on every beat). The slave may assert wbs_ack_i only in cycles where wbs_bry_o=1.
- Routing: decode on the first beat when route=NONE. route=LOCAL on hit, otherwise FWD. Route locks until the transaction's beats are consumed (write: bl beats; read: 1 beat), then returns to NONE. bl=0 is treated as 1.
- FWD: wbd_cmd_* = wbp_cmd_*; wbd_cmd_wval_o = wval_i & FWD; wrdy_o = wbd_cmd_wrdy_i. Combinational, zero latency.
- FSM states:
  - IDLE: on wval & hit, accept the beat (wrdy_o=1 when FSM is IDLE); latch adr/we/sel/tid/bl/dat; beat_cnt=bl; next state RD or WR.
  - RD: cyc=stb=1, we=0, wbs_bl_o=bl; bry = !fifo_full. Each ack pushes {dat_i, ack=1, err_i, tid, lack} where lack = (beat_cnt==1) | wbs_lack_i | wbs_err_i; beat_cnt decrements. On lack → DONE.
  - WR: stb=1 with latched data. Each ack decrements beat_cnt. For a non-last beat, wrdy_o=1 in the ack cycle so the next beat loads with no bubble (stb stays high). For the last beat, bry = !fifo_full; the ack pushes one response {dat=0, ack=1, lack=1, err=OR of all err_i in the burst, tid} → DONE. An err on a non-last beat is recorded sticky; the burst continues.
  - DONE: cyc=stb=0 for 1 cycle; route→NONE; → IDLE.
- Upstream response merge: two sources, local FIFO head and wbd_res. With both valid, the grant alternates per beat (round-robin). Grant is held while the selected source is valid and wbp_res_rrdy_i=0, so no switch occurs while stalled. Output path is combinational. The non-selected source sees rrdy=0.
- FIFO full: a full FIFO holds bry low; there is no overflow and no drop. Simultaneous push and pop at full is allowed and count is unchanged.
- Reset mid-transaction: immediate abort; cyc/stb drop asynchronously; FIFO is flushed.

Decomposition:
- Shared package wbi_pkg:
  - route enum {NONE, LOCAL, FWD}
  - FSM enum {IDLE, RD, WR, DONE}
  - response struct {dat, ack, lack, err, tid}
- One sub-module: wbi_res_fifo, a parameterised sync valid/ready FIFO (width = DW+7, depth RDP). Top-level: decode, FSM, merge arbiter.

Test Plan:
- Read hit: BASE=0x3000_0000, adr=0x3000_0010, bl=1, tid=2; slave returns 0xDEADBEEF → one wbp response: dat=0xDEADBEEF, ack=1, lack=1, err=0, tid=2; wbd_cmd_wval_o never high.
- Miss: adr=0x1000_0000 → wbd_cmd_* mirrors input in the same cycle; wbs_cyc_o stays 0; held wbd_cmd_wrdy_i=0 gives wrdy_o=0.
- Write burst: bl=4, data 1..4, tid=5, slave acks back-to-back → wbs_dat_o sequence 1,2,3,4 with stb continuous; exactly one response: ack=1, lack=1, err=0, tid=5.
- Read burst bl=4 with err_i on beat 2 → 2 responses; the second has err=1, lack=1; FSM returns to IDLE.
- Merge: local and downstream both valid, rrdy toggling 1,0,1,1 → grants alternate local/down/local with no switch on the stalled cycle; FIFO full (RDP=2, rrdy=0) → wbs_bry_o=0.
- Reset asserted during read burst beat 2 → all outputs 0 immediately; after release, a new read hit completes normally.
